// File: rtl/ide_pio_seq_pkg.sv
// ide_pkg: definitions shared by the IDE PIO sequencer and its users.
//  - ide_state_t : sequencer phase encoding (IDLE/SETUP/PULSE/HOLD/DONE)
//  - IDE_CS_IDLE : chip-select value with both selects deasserted
//  - REG_*       : task-file register addresses as {cs[1:0],da[2:0]}
//  - phase_len() : clamps a phase length parameter into the 4-bit counter range
package ide_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_PULSE,
      ST_HOLD,
      ST_DONE
   } ide_state_t;

   localparam logic [1:0] IDE_CS_IDLE = 2'b11;

   // Command block (CS0 asserted, cs=2'b10) and control block (CS1 asserted, cs=2'b01).
   localparam logic [4:0] REG_DATA    = 5'b10000;
   localparam logic [4:0] REG_ERROR   = 5'b10001;
   localparam logic [4:0] REG_SECCNT  = 5'b10010;
   localparam logic [4:0] REG_LBA0    = 5'b10011;
   localparam logic [4:0] REG_LBA1    = 5'b10100;
   localparam logic [4:0] REG_LBA2    = 5'b10101;
   localparam logic [4:0] REG_DRVHD   = 5'b10110;
   localparam logic [4:0] REG_CMD     = 5'b10111;
   localparam logic [4:0] REG_STATUS  = 5'b10111;
   localparam logic [4:0] REG_ALTSTAT = 5'b01110;

   // A zero-length phase would never see the counter reach 1, so it is stretched to one
   // cycle; lengths beyond the 4-bit counter saturate at 15.
   function automatic logic [3:0] phase_len(input int t);
      if (t < 1) return 4'd1;
      if (t > 15) return 4'd15;
      return t[3:0];
   endfunction

endpackage

// File: rtl/ide_pio_seq_if.sv
// ide_pio_seq_if: host-side request/response bundle of the IDE PIO sequencer.
//  req/we/addr/wdata : one-cycle request from the disk controller (master drives)
//  rdata/busy/done   : read data, in-progress flag, completion pulse (slave drives)
interface ide_pio_seq_if;
   logic        req;
   logic        we;
   logic [4:0]  addr;
   logic [15:0] wdata;
   logic [15:0] rdata;
   logic        busy;
   logic        done;

   modport master (output req, we, addr, wdata, input rdata, busy, done);
   modport slave  (input req, we, addr, wdata, output rdata, busy, done);
endinterface

// File: rtl/ide_pio_seq_phase_ctr.sv
// ide_phase_ctr: loadable 4-bit phase down-counter for the IDE PIO sequencer.
//  clk, srst         : clock, synchronous active-high reset
//  load, load_val    : start a phase of load_val cycles
//  last              : high during the final cycle of the current phase
//  With IDE_IORDY_EN an 8-bit wait counter is added:
//  wait_clr, wait_inc: clear / count one iordy extension cycle
//  wait_max          : extension cap (255 cycles) reached
module ide_phase_ctr (
   input  logic       clk,
   input  logic       srst,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic       last
`ifdef IDE_IORDY_EN
   ,
   input  logic       wait_clr,
   input  logic       wait_inc,
   output logic       wait_max
`endif
);

   logic [3:0] cnt_reg;

   // The count parks at 1 so that 'last' stays asserted while a phase is extended.
   always_ff @(posedge clk) begin
      if (srst)
         cnt_reg <= 4'd1;
      else if (load)
         cnt_reg <= load_val;
      else if (cnt_reg > 4'd1)
         cnt_reg <= cnt_reg - 4'd1;
   end

   assign last = (cnt_reg == 4'd1);

`ifdef IDE_IORDY_EN
   logic [7:0] wait_reg;

   always_ff @(posedge clk) begin
      if (srst || wait_clr)
         wait_reg <= 8'd0;
      else if (wait_inc && (wait_reg != 8'hFF))
         wait_reg <= wait_reg + 8'd1;
   end

   assign wait_max = (wait_reg == 8'hFF);
`endif

endmodule

// File: rtl/ide_pio_seq.sv
// ide_pio_seq: host-side IDE/ATA PIO bus sequencer.
// Turns a one-cycle register read/write request into timed cs/da/dior/diow strobes and
// the 16-bit data bus, one transaction at a time, with all pin outputs registered.
//  clk, reset     : system clock, synchronous active-high reset
//  host (slave)   : req/we/addr/wdata in, rdata/busy/done out
//  ide_data_in    : data bus as seen on the pins
//  ide_data_out/oe: data bus drive value and enable
//  ide_dior/diow  : read/write strobes, active low
//  ide_cs/ide_da  : chip selects and register address
//  ide_iordy      : device ready, only when IDE_IORDY_EN is defined
// Optional feature: IDE_IORDY_EN stretches the strobe while iordy is low (max 255 cycles).
module ide_pio_seq
   import ide_pkg::*;
#(
   parameter int T_SETUP = 4,
   parameter int T_PULSE = 9,
   parameter int T_HOLD  = 2
) (
   input  logic          clk,
   input  logic          reset,
   ide_pio_seq_if.slave  host,
   input  logic [15:0]   ide_data_in,
   output logic [15:0]   ide_data_out,
   output logic          ide_data_oe,
   output logic          ide_dior,
   output logic          ide_diow,
   output logic [1:0]    ide_cs,
   output logic [2:0]    ide_da
`ifdef IDE_IORDY_EN
   ,
   input  logic          ide_iordy
`endif
);

   localparam logic [3:0] LEN_SETUP = phase_len(T_SETUP);
   localparam logic [3:0] LEN_PULSE = phase_len(T_PULSE);
   localparam logic [3:0] LEN_HOLD  = phase_len(T_HOLD);

   ide_state_t state_reg;
   logic       we_reg;
   logic       ctr_load;
   logic [3:0] ctr_val;
   logic       ctr_last;
   logic       pulse_end;

`ifdef IDE_IORDY_EN
   logic wait_max;
   logic wait_inc;
   logic wait_clr;

   // After the minimum pulse, hold the strobe while the device is not ready, up to the cap.
   assign pulse_end = ctr_last & (ide_iordy | wait_max);
   assign wait_inc  = (state_reg == ST_PULSE) & ctr_last & ~ide_iordy;
   assign wait_clr  = (state_reg != ST_PULSE);
`else
   assign pulse_end = ctr_last;
`endif

   ide_phase_ctr u_ctr (
      .clk      (clk),
      .srst     (reset),
      .load     (ctr_load),
      .load_val (ctr_val),
      .last     (ctr_last)
`ifdef IDE_IORDY_EN
      ,
      .wait_clr (wait_clr),
      .wait_inc (wait_inc),
      .wait_max (wait_max)
`endif
   );

   // The counter is reloaded on the same edge that moves the FSM into the next phase.
   always_comb begin
      ctr_load = 1'b0;
      ctr_val  = LEN_SETUP;
      case (state_reg)
         ST_IDLE:  ctr_load = host.req;
         ST_SETUP: begin
            ctr_load = ctr_last;
            ctr_val  = LEN_PULSE;
         end
         ST_PULSE: begin
            ctr_load = pulse_end;
            ctr_val  = LEN_HOLD;
         end
         default:  ctr_load = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         we_reg       <= 1'b0;
         ide_dior     <= 1'b1;
         ide_diow     <= 1'b1;
         ide_data_oe  <= 1'b0;
         ide_data_out <= 16'h0000;
         ide_cs       <= IDE_CS_IDLE;
         ide_da       <= 3'd0;
         host.busy    <= 1'b0;
         host.done    <= 1'b0;
         host.rdata   <= 16'h0000;
      end else begin
         host.done <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (host.req) begin
                  state_reg <= ST_SETUP;
                  we_reg    <= host.we;
                  ide_cs    <= host.addr[4:3];
                  ide_da    <= host.addr[2:0];
                  host.busy <= 1'b1;
                  if (host.we) begin
                     ide_data_oe  <= 1'b1;
                     ide_data_out <= host.wdata;
                  end
               end
            end
            ST_SETUP: begin
               if (ctr_last) begin
                  state_reg <= ST_PULSE;
                  if (we_reg)
                     ide_diow <= 1'b0;
                  else
                     ide_dior <= 1'b0;
               end
            end
            ST_PULSE: begin
               // Read data is captured on the same edge that releases the strobe.
               if (pulse_end) begin
                  state_reg <= ST_HOLD;
                  ide_dior  <= 1'b1;
                  ide_diow  <= 1'b1;
                  if (!we_reg)
                     host.rdata <= ide_data_in;
               end
            end
            ST_HOLD: begin
               if (ctr_last) begin
                  state_reg   <= ST_DONE;
                  ide_data_oe <= 1'b0;
                  ide_cs      <= IDE_CS_IDLE;
                  host.busy   <= 1'b0;
                  host.done   <= 1'b1;
               end
            end
            ST_DONE:  state_reg <= ST_IDLE;
            default:  state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ide_pio_seq.sv
// tb_ide_pio_seq: randomized scoreboard bench for ide_pio_seq.
// Stimulus pushes the expected outcome of every request the DUT should accept; a monitor
// accumulates pin activity per transaction and compares it on each done pulse.
// A second instance with minimal phase lengths checks the short-timing corner.
`timescale 1ns/1ps
module tb_ide_pio_seq;
   import ide_pkg::*;

   localparam int TS  = 4;
   localparam int TP  = 9;
   localparam int TH  = 2;
   localparam int LAT = TS + TP + TH;   // accept edge to done-visible edge
   localparam int GAP = LAT + 2;        // accept edge to next possible accept edge

   typedef struct {
      int          done_cyc;
      logic        we;
      logic [4:0]  addr;
      logic [15:0] wdata;
      int          sample_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Main DUT
   ide_pio_seq_if hif ();
   logic [15:0] din;
   logic [15:0] dout;
   logic        oe, dior, diow;
   logic [1:0]  cs;
   logic [2:0]  da;

   ide_pio_seq #(.T_SETUP(TS), .T_PULSE(TP), .T_HOLD(TH)) dut (
      .clk          (clk),
      .reset        (reset),
      .host         (hif),
      .ide_data_in  (din),
      .ide_data_out (dout),
      .ide_data_oe  (oe),
      .ide_dior     (dior),
      .ide_diow     (diow),
      .ide_cs       (cs),
      .ide_da       (da)
`ifdef IDE_IORDY_EN
      ,
      .ide_iordy    (1'b1)
`endif
   );

   // Short-timing DUT: setup 0 (treated as 1), pulse 1, hold 1
   ide_pio_seq_if hif2 ();
   logic [15:0] din2;
   logic [15:0] dout2;
   logic        oe2, dior2, diow2;
   logic [1:0]  cs2;
   logic [2:0]  da2;

   ide_pio_seq #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(1)) dut2 (
      .clk          (clk),
      .reset        (reset),
      .host         (hif2),
      .ide_data_in  (din2),
      .ide_data_out (dout2),
      .ide_data_oe  (oe2),
      .ide_dior     (dior2),
      .ide_diow     (diow2),
      .ide_cs       (cs2),
      .ide_da       (da2)
`ifdef IDE_IORDY_EN
      ,
      .ide_iordy    (1'b1)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      n_vec++;
      if (act !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // ---------------- reference model ----------------
   exp_t        exp_q[$];
   logic [15:0] din_hist [0:8191];
   int          free_edge = 0;
   bit          model_en = 0;
   bit          din_fix_en = 0;

   // One stimulus cycle: apply inputs before edge cyc+1 and predict whether it is accepted.
   task automatic drive(input logic r, input logic w, input logic [4:0] a, input logic [15:0] d);
      exp_t e;
      @(negedge clk);
      hif.req   = r;
      hif.we    = w;
      hif.addr  = a;
      hif.wdata = d;
      din = din_fix_en ? 16'h0050 : 16'($urandom);
      din_hist[cyc % 8192] = din;
      if (r && model_en && (cyc + 1 >= free_edge)) begin
         e.done_cyc   = cyc + 1 + LAT;
         e.we         = w;
         e.addr       = a;
         e.wdata      = d;
         e.sample_cyc = cyc + TS + TP;
         exp_q.push_back(e);
         free_edge = cyc + 1 + GAP;
      end
   endtask

   function automatic logic [4:0] rand_addr();
      logic [1:0] c;
      c = ($urandom_range(0, 1) == 0) ? 2'b10 : 2'b01;
      return {c, 3'($urandom)};
   endfunction

   // ---------------- monitor ----------------
   bit          mon_en = 0;
   int          dior_low, diow_low, dior_fall, diow_fall;
   int          cs_act, cs_match, oe_cnt, dout_bad, busy_cnt;
   int          n_txn = 0;
   logic        dior_q = 1'b1, diow_q = 1'b1;
   logic [15:0] last_rd = 16'h0000;
   exp_t        me;

   task automatic clear_counts();
      dior_low = 0; diow_low = 0; dior_fall = 0; diow_fall = 0;
      cs_act = 0; cs_match = 0; oe_cnt = 0; dout_bad = 0; busy_cnt = 0;
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         if (!dior) dior_low++;
         if (!diow) diow_low++;
         if (dior_q && !dior) dior_fall++;
         if (diow_q && !diow) diow_fall++;
         if (cs != IDE_CS_IDLE) begin
            cs_act++;
            if (exp_q.size() > 0 && {cs, da} == exp_q[0].addr) cs_match++;
         end
         if (oe) begin
            oe_cnt++;
            if (exp_q.size() == 0 || dout !== exp_q[0].wdata) dout_bad++;
         end
         if (hif.busy) busy_cnt++;
         if (hif.done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               me = exp_q.pop_front();
               n_txn++;
               chk("done_cycle", cyc, me.done_cyc);
               chk("busy_cycles", busy_cnt, LAT);
               chk("cs_active_cycles", cs_act, LAT);
               chk("cs_da_match_cycles", cs_match, LAT);
               chk("data_out_bad_cycles", dout_bad, 0);
               if (me.we) begin
                  chk("wr_diow_low", diow_low, TP);
                  chk("wr_diow_falls", diow_fall, 1);
                  chk("wr_dior_low", dior_low, 0);
                  chk("wr_oe_cycles", oe_cnt, LAT);
                  chk("wr_rdata_held", hif.rdata, last_rd);
               end else begin
                  last_rd = din_hist[me.sample_cyc % 8192];
                  chk("rd_dior_low", dior_low, TP);
                  chk("rd_dior_falls", dior_fall, 1);
                  chk("rd_diow_low", diow_low, 0);
                  chk("rd_oe_cycles", oe_cnt, 0);
                  chk("rd_rdata", hif.rdata, last_rd);
               end
               $display("txn %0d cyc %0d: we=%0b addr=%02h wdata=%04h rdata=%04h",
                        n_txn, cyc, me.we, me.addr, me.wdata, hif.rdata);
            end
            clear_counts();
         end else if (exp_q.size() > 0 && cyc > exp_q[0].done_cyc) begin
            chk("done_missing", 32'd0, 32'd1);
            void'(exp_q.pop_front());
            clear_counts();
         end
      end
      dior_q = dior;
      diow_q = diow;
   end

   // ---------------- stimulus ----------------
   initial begin
      int a;
      int dn;
      int done_at;
      int low2;
      logic [15:0] v2;

      clear_counts();
      reset = 1'b1;
      hif.req = 1'b0; hif.we = 1'b0; hif.addr = 5'd0; hif.wdata = 16'h0;
      hif2.req = 1'b0; hif2.we = 1'b0; hif2.addr = 5'd0; hif2.wdata = 16'h0;
      din = 16'h0; din2 = 16'h0;
      repeat (3) @(negedge clk);

      // Reset state
      chk("rst_dior", dior, 1'b1);
      chk("rst_diow", diow, 1'b1);
      chk("rst_oe", oe, 1'b0);
      chk("rst_cs", cs, IDE_CS_IDLE);
      chk("rst_da", da, 3'd0);
      chk("rst_busy", hif.busy, 1'b0);
      chk("rst_done", hif.done, 1'b0);
      chk("rst_rdata", hif.rdata, 16'h0);
      chk("rst_data_out", dout, 16'h0);
      reset = 1'b0;

      model_en = 1;
      mon_en = 1;

      // Directed read of STATUS with the disk returning 0x0050, then directed write
      din_fix_en = 1;
      drive(1'b1, 1'b0, REG_STATUS, 16'h0);
      repeat (20) drive(1'b0, 1'b0, rand_addr(), 16'($urandom));
      din_fix_en = 0;
      drive(1'b1, 1'b1, REG_DATA, 16'hA55A);
      repeat (20) drive(1'b0, 1'b1, rand_addr(), 16'($urandom));

      // Back-to-back: req held high, inputs changing every cycle
      repeat (4 * GAP + 3) drive(1'b1, 1'($urandom), rand_addr(), 16'($urandom));

      // Random traffic
      repeat (600) drive(1'($urandom_range(0, 3) == 0), 1'($urandom), rand_addr(), 16'($urandom));

      // Drain, bounded
      for (int i = 0; i < 100 && exp_q.size() > 0; i++) drive(1'b0, 1'b0, 5'd0, 16'h0);
      chk("drain_queue_empty", exp_q.size(), 0);

      // Reset abort in the middle of a write pulse
      model_en = 0;
      mon_en = 0;
      repeat (3) drive(1'b0, 1'b0, 5'd0, 16'h0);
      @(negedge clk);
      hif.req = 1'b1; hif.we = 1'b1; hif.addr = REG_DATA; hif.wdata = 16'h1234;
      a = cyc + 1;
      @(negedge clk);
      hif.req = 1'b0;
      while (cyc < a + 7) @(negedge clk);
      chk("abort_mid_pulse_diow", diow, 1'b0);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_dior", dior, 1'b1);
      chk("abort_diow", diow, 1'b1);
      chk("abort_oe", oe, 1'b0);
      chk("abort_cs", cs, IDE_CS_IDLE);
      chk("abort_busy", hif.busy, 1'b0);
      reset = 1'b0;
      dn = 0;
      repeat (25) begin
         @(negedge clk);
         if (hif.done) dn++;
      end
      chk("abort_no_done", dn, 0);

      // Short-timing instance: single read, phases of one cycle each
      v2 = 16'($urandom);
      @(negedge clk);
      din2 = v2;
      hif2.req = 1'b1; hif2.we = 1'b0; hif2.addr = REG_LBA1;
      a = cyc + 1;
      done_at = -1;
      low2 = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         hif2.req = 1'b0;
         if (!dior2) low2++;
         if (hif2.done && done_at < 0) done_at = cyc;
      end
      chk("short_done_cycle", done_at, a + 3);
      chk("short_dior_low", low2, 1);
      chk("short_rdata", hif2.rdata, v2);
      $display("txn short cyc %0d: addr=%02h rdata=%04h", done_at, REG_LBA1, hif2.rdata);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
